wall_bounce_controller: RTL and testbench

//  Per-frame collision sequencer for the ball.

---
 rtl/wall_bounce_controller.sv | 156 +++++++++++++++
 tb/tb_wall_bounce_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wall_bounce_controller.sv
// Per-frame wall collision sequencer: X walls first, then Y walls, using an external reflection unit.
// Optional BOUNCE_COUNT_EN adds a saturating count of frames that reflected at least once.
module wall_bounce_controller #(
    parameter int POS_W = 11,
    parameter int X_MIN = 0,
    parameter int X_MAX = 1023,
    parameter int Y_MIN = 0,
    parameter int Y_MAX = 767
`ifdef BOUNCE_COUNT_EN
    ,
    parameter int BOUNCE_W = 8
`endif
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [POS_W-1:0] x_in,
    input  logic [POS_W-1:0] y_in,
    input  logic [15:0]      dir_in,
    input  logic [15:0]      reflect_result_in,
    output logic [15:0]      reflect_dir_out,
    output logic [1:0]       reflect_wall_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [POS_W-1:0] x_out,
    output logic [POS_W-1:0] y_out,
    output logic [15:0]      dir_out,
    output logic [3:0]       hit_mask_out
`ifdef BOUNCE_COUNT_EN
    ,
    input  logic                bounce_clr_in,
    output logic [BOUNCE_W-1:0] bounce_count_out
`endif
);

    localparam logic [POS_W-1:0] XMIN_P = POS_W'(X_MIN);
    localparam logic [POS_W-1:0] XMAX_P = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] YMIN_P = POS_W'(Y_MIN);
    localparam logic [POS_W-1:0] YMAX_P = POS_W'(Y_MAX);

    typedef enum logic [2:0] {IDLE, CHECK_X, WAIT_X, CHECK_Y, WAIT_Y, DONE} state_t;

    state_t           state_reg, state_next;
    logic [POS_W-1:0] x_reg, y_reg, x_out_reg, y_out_reg;
    logic [15:0]      dir_reg, dir_out_reg, rdir_reg;
    logic [1:0]       rwall_reg;
    logic [3:0]       mask_reg, mask_out_reg;
    logic             done_reg;
    logic             hit_x0, hit_x2, hit_y1, hit_y3;
    logic [15:0]      result_wrapped;

    // Headings exactly parallel to a wall are never treated as approaching it.
    assign hit_x0 = (x_reg >= XMAX_P) && ((dir_reg < 16'd90) || (dir_reg > 16'd270));
    assign hit_x2 = (x_reg <= XMIN_P) && (dir_reg > 16'd90) && (dir_reg < 16'd270);
    assign hit_y1 = (y_reg >= YMAX_P) && (dir_reg > 16'd0) && (dir_reg < 16'd180);
    assign hit_y3 = (y_reg <= YMIN_P) && (dir_reg > 16'd180) && (dir_reg < 16'd360);

    assign result_wrapped = (reflect_result_in >= 16'd360) ? (reflect_result_in - 16'd360)
                                                           : reflect_result_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_reg <= IDLE;
        else           state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_in) state_next = CHECK_X;
            CHECK_X: state_next = (hit_x0 || hit_x2) ? WAIT_X : CHECK_Y;
            WAIT_X:  state_next = CHECK_Y;
            CHECK_Y: state_next = (hit_y1 || hit_y3) ? WAIT_Y : DONE;
            WAIT_Y:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_reg        <= '0;
            y_reg        <= '0;
            dir_reg      <= '0;
            mask_reg     <= '0;
            rdir_reg     <= '0;
            rwall_reg    <= '0;
            x_out_reg    <= '0;
            y_out_reg    <= '0;
            dir_out_reg  <= '0;
            mask_out_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: if (start_in) begin
                    x_reg    <= x_in;
                    y_reg    <= y_in;
                    dir_reg  <= dir_in;
                    mask_reg <= '0;
                end
                CHECK_X: if (hit_x0 || hit_x2) begin
                    rwall_reg <= hit_x0 ? 2'd0 : 2'd2;
                    rdir_reg  <= dir_reg;
                end
                WAIT_X: begin
                    dir_reg  <= result_wrapped;
                    x_reg    <= (rwall_reg == 2'd0) ? XMAX_P : XMIN_P;
                    mask_reg <= mask_reg | (4'b0001 << rwall_reg);
                end
                CHECK_Y: if (hit_y1 || hit_y3) begin
                    rwall_reg <= hit_y1 ? 2'd1 : 2'd3;
                    rdir_reg  <= dir_reg;
                end
                WAIT_Y: begin
                    dir_reg  <= result_wrapped;
                    y_reg    <= (rwall_reg == 2'd1) ? YMAX_P : YMIN_P;
                    mask_reg <= mask_reg | (4'b0001 << rwall_reg);
                end
                DONE: begin
                    x_out_reg    <= x_reg;
                    y_out_reg    <= y_reg;
                    dir_out_reg  <= dir_reg;
                    mask_out_reg <= mask_reg;
                    done_reg     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BOUNCE_COUNT_EN
    logic [BOUNCE_W-1:0] bounce_cnt_reg;

    // Clear has priority over an increment landing in the same cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            bounce_cnt_reg <= '0;
        else if (bounce_clr_in)
            bounce_cnt_reg <= '0;
        else if ((state_reg == DONE) && (mask_reg != 4'd0) && (bounce_cnt_reg != '1))
            bounce_cnt_reg <= bounce_cnt_reg + 1'b1;
    end

    assign bounce_count_out = bounce_cnt_reg;
`endif

    assign busy_out         = (state_reg != IDLE);
    assign done_out         = done_reg;
    assign x_out            = x_out_reg;
    assign y_out            = y_out_reg;
    assign dir_out          = dir_out_reg;
    assign hit_mask_out     = mask_out_reg;
    assign reflect_dir_out  = rdir_reg;
    assign reflect_wall_out = rwall_reg;

endmodule

// File: tb/tb_wall_bounce_controller.sv
// Directed bench for wall_bounce_controller with a behavioural reflection unit.
// Define BOUNCE_COUNT_EN to also exercise the bounce counter with a 2-bit width.
module tb_wall_bounce_controller;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        start_in = 1'b0;
    logic [10:0] x_in = '0, y_in = '0;
    logic [15:0] dir_in = '0;
    logic [15:0] reflect_result_in;
    logic [15:0] reflect_dir_out;
    logic [1:0]  reflect_wall_out;
    logic        busy_out, done_out;
    logic [10:0] x_out, y_out;
    logic [15:0] dir_out;
    logic [3:0]  hit_mask_out;
`ifdef BOUNCE_COUNT_EN
    logic        bounce_clr_in = 1'b0;
    logic [1:0]  bounce_count_out;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk_in = ~clk_in;

    // Reflection unit: X walls mirror to 180-d, Y walls to 360-d, both offset by +360 so the
    // controller's wrap-down path is exercised.
    always_comb begin
        if (reflect_wall_out[0] == 1'b0) reflect_result_in = 16'd540 - reflect_dir_out;
        else                             reflect_result_in = 16'd720 - reflect_dir_out;
    end

    wall_bounce_controller #(
        .POS_W(11), .X_MIN(0), .X_MAX(1023), .Y_MIN(0), .Y_MAX(767)
`ifdef BOUNCE_COUNT_EN
        , .BOUNCE_W(2)
`endif
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
        .x_in(x_in), .y_in(y_in), .dir_in(dir_in),
        .reflect_result_in(reflect_result_in),
        .reflect_dir_out(reflect_dir_out), .reflect_wall_out(reflect_wall_out),
        .busy_out(busy_out), .done_out(done_out),
        .x_out(x_out), .y_out(y_out), .dir_out(dir_out), .hit_mask_out(hit_mask_out)
`ifdef BOUNCE_COUNT_EN
        , .bounce_clr_in(bounce_clr_in), .bounce_count_out(bounce_count_out)
`endif
    );

    // Call #1 after a rising edge; returns #1 after the edge where done_out rose (lat=-1 on timeout).
    task automatic run_frame(input int x, input int y, input int d, output int lat);
        x_in = 11'(x); y_in = 11'(y); dir_in = 16'(d);
        start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        lat = 0;
        while (!done_out && lat < 20) begin
            @(posedge clk_in); #1;
            lat++;
        end
        if (!done_out) lat = -1;
        $display("frame x=%0d y=%0d dir=%0d -> lat=%0d x=%0d y=%0d dir=%0d mask=%b",
                 x, y, d, lat, x_out, y_out, dir_out, hit_mask_out);
    endtask

    task automatic test_reset();
        checks++; if (busy_out !== 1'b0) $display("FAIL rst_busy got %b want 0", busy_out); else passed++;
        checks++; if (done_out !== 1'b0) $display("FAIL rst_done got %b want 0", done_out); else passed++;
        checks++; if ({x_out, y_out, dir_out, hit_mask_out} !== 42'd0)
            $display("FAIL rst_outputs got x=%0d y=%0d dir=%0d mask=%b want 0", x_out, y_out, dir_out, hit_mask_out); else passed++;
        checks++; if ({reflect_dir_out, reflect_wall_out} !== 18'd0)
            $display("FAIL rst_reflect got dir=%0d wall=%0d want 0", reflect_dir_out, reflect_wall_out); else passed++;
    endtask

    task automatic test_no_hit();
        int lat;
        run_frame(500, 300, 45, lat);
        checks++; if (lat !== 3) $display("FAIL nohit_lat got %0d want 3", lat); else passed++;
        checks++; if ({x_out, y_out, dir_out, hit_mask_out} !== {11'd500, 11'd300, 16'd45, 4'b0000})
            $display("FAIL nohit_result got x=%0d y=%0d dir=%0d mask=%b want 500 300 45 0000", x_out, y_out, dir_out, hit_mask_out); else passed++;
        checks++; if (busy_out !== 1'b0) $display("FAIL nohit_busy got %b want 0", busy_out); else passed++;
        @(posedge clk_in); #1;
        checks++; if (done_out !== 1'b0) $display("FAIL nohit_pulse got %b want 0", done_out); else passed++;
        checks++; if (x_out !== 11'd500) $display("FAIL nohit_hold got %0d want 500", x_out); else passed++;
    endtask

    task automatic test_single_hit();
        int lat;
        run_frame(1030, 300, 30, lat);
        checks++; if (lat !== 4) $display("FAIL hit0_lat got %0d want 4", lat); else passed++;
        checks++; if ({reflect_wall_out, reflect_dir_out} !== {2'd0, 16'd30})
            $display("FAIL hit0_reflect got wall=%0d dir=%0d want 0 30", reflect_wall_out, reflect_dir_out); else passed++;
        checks++; if ({x_out, y_out, dir_out, hit_mask_out} !== {11'd1023, 11'd300, 16'd150, 4'b0001})
            $display("FAIL hit0_result got x=%0d y=%0d dir=%0d mask=%b want 1023 300 150 0001", x_out, y_out, dir_out, hit_mask_out); else passed++;
        run_frame(500, 0, 300, lat);
        checks++; if (lat !== 4) $display("FAIL hit3_lat got %0d want 4", lat); else passed++;
        checks++; if ({x_out, y_out, dir_out, hit_mask_out} !== {11'd500, 11'd0, 16'd60, 4'b1000})
            $display("FAIL hit3_result got x=%0d y=%0d dir=%0d mask=%b want 500 0 60 1000", x_out, y_out, dir_out, hit_mask_out); else passed++;
    endtask

    task automatic test_corner();
        int lat;
        run_frame(1030, 770, 45, lat);
        checks++; if (lat !== 5) $display("FAIL corner_lat got %0d want 5", lat); else passed++;
        checks++; if ({x_out, y_out, dir_out, hit_mask_out} !== {11'd1023, 11'd767, 16'd225, 4'b0011})
            $display("FAIL corner_result got x=%0d y=%0d dir=%0d mask=%b want 1023 767 225 0011", x_out, y_out, dir_out, hit_mask_out); else passed++;
        checks++; if ({reflect_wall_out, reflect_dir_out} !== {2'd1, 16'd135})
            $display("FAIL corner_reflect got wall=%0d dir=%0d want 1 135", reflect_wall_out, reflect_dir_out); else passed++;
    endtask

    task automatic test_boundaries();
        int lat;
        run_frame(0, 0, 180, lat);
        checks++; if ({lat, x_out, y_out, dir_out, hit_mask_out} !== {32'd4, 11'd0, 11'd0, 16'd0, 4'b0100})
            $display("FAIL wall2_result got lat=%0d x=%0d y=%0d dir=%0d mask=%b want 4 0 0 0 0100", lat, x_out, y_out, dir_out, hit_mask_out); else passed++;
        run_frame(1100, 300, 180, lat);
        checks++; if ({lat, x_out, y_out, dir_out, hit_mask_out} !== {32'd3, 11'd1100, 11'd300, 16'd180, 4'b0000})
            $display("FAIL away_result got lat=%0d x=%0d y=%0d dir=%0d mask=%b want 3 1100 300 180 0000", lat, x_out, y_out, dir_out, hit_mask_out); else passed++;
        run_frame(1023, 767, 0, lat);
        checks++; if ({lat, x_out, y_out, dir_out, hit_mask_out} !== {32'd4, 11'd1023, 11'd767, 16'd180, 4'b0001})
            $display("FAIL edge0_result got lat=%0d x=%0d y=%0d dir=%0d mask=%b want 4 1023 767 180 0001", lat, x_out, y_out, dir_out, hit_mask_out); else passed++;
        run_frame(1023, 300, 270, lat);
        checks++; if ({lat, x_out, dir_out, hit_mask_out} !== {32'd3, 11'd1023, 16'd270, 4'b0000})
            $display("FAIL par270_result got lat=%0d x=%0d dir=%0d mask=%b want 3 1023 270 0000", lat, x_out, dir_out, hit_mask_out); else passed++;
    endtask

    task automatic test_busy_ignore();
        int dones = 0;
        x_in = 11'd1030; y_in = 11'd300; dir_in = 16'd30;
        start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        @(posedge clk_in); #1;
        checks++; if (busy_out !== 1'b1) $display("FAIL busy_high got %b want 1", busy_out); else passed++;
        start_in = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk_in); #1;
            if (i == 2) start_in = 1'b0;
            if (done_out) dones++;
        end
        $display("busy_ignore dones=%0d", dones);
        checks++; if (dones !== 1) $display("FAIL busy_dones got %0d want 1", dones); else passed++;
        checks++; if ({x_out, dir_out, hit_mask_out} !== {11'd1023, 16'd150, 4'b0001})
            $display("FAIL busy_result got x=%0d dir=%0d mask=%b want 1023 150 0001", x_out, dir_out, hit_mask_out); else passed++;
    endtask

    task automatic test_async_reset();
        int dones = 0;
        int lat;
        x_in = 11'd1030; y_in = 11'd300; dir_in = 16'd30;
        start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        @(posedge clk_in); #2;
        rst_n_in = 1'b0;
        #1;
        checks++; if ({busy_out, done_out, x_out, y_out, dir_out, hit_mask_out} !== 44'd0)
            $display("FAIL arst_outputs got busy=%b x=%0d dir=%0d mask=%b want 0", busy_out, x_out, dir_out, hit_mask_out); else passed++;
        checks++; if ({reflect_dir_out, reflect_wall_out} !== 18'd0)
            $display("FAIL arst_reflect got dir=%0d wall=%0d want 0", reflect_dir_out, reflect_wall_out); else passed++;
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_in); #1;
            if (done_out || busy_out) dones++;
        end
        $display("async_reset stray_activity=%0d", dones);
        checks++; if (dones !== 0) $display("FAIL arst_nodone got %0d want 0", dones); else passed++;
        run_frame(500, 300, 45, lat);
        checks++; if ({lat, x_out, y_out, dir_out, hit_mask_out} !== {32'd3, 11'd500, 11'd300, 16'd45, 4'b0000})
            $display("FAIL arst_after got lat=%0d x=%0d y=%0d dir=%0d mask=%b want 3 500 300 45 0000", lat, x_out, y_out, dir_out, hit_mask_out); else passed++;
    endtask

`ifdef BOUNCE_COUNT_EN
    task automatic test_bounce_count();
        int lat;
        logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bounce_clr_in = 1'b1;
        @(posedge clk_in); #1;
        bounce_clr_in = 1'b0;
        checks++; if (bounce_count_out !== 2'd0) $display("FAIL cnt_clear got %0d want 0", bounce_count_out); else passed++;
        for (int i = 0; i < 5; i++) begin
            run_frame(1030, 300, 30, lat);
            checks++; if (bounce_count_out !== want[i])
                $display("FAIL cnt_frame%0d got %0d want %0d", i, bounce_count_out, want[i]); else passed++;
        end
        run_frame(500, 300, 45, lat);
        checks++; if (bounce_count_out !== 2'd3) $display("FAIL cnt_nohit got %0d want 3", bounce_count_out); else passed++;
        // Hit frame: the DONE state occupies the cycle after the third edge following start.
        x_in = 11'd1030; y_in = 11'd300; dir_in = 16'd30;
        start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 bounce_clr_in = 1'b1;
        @(posedge clk_in); #1;
        bounce_clr_in = 1'b0;
        checks++; if ({done_out, bounce_count_out} !== {1'b1, 2'd0})
            $display("FAIL cnt_clr_done got done=%b cnt=%0d want 1 0", done_out, bounce_count_out); else passed++;
        run_frame(1030, 300, 30, lat);
        checks++; if (bounce_count_out !== 2'd1) $display("FAIL cnt_after_clr got %0d want 1", bounce_count_out); else passed++;
    endtask
`endif

    initial begin
        rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        test_reset();
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        test_no_hit();
        test_single_hit();
        test_corner();
        test_boundaries();
        test_busy_ignore();
        test_async_reset();
`ifdef BOUNCE_COUNT_EN
        test_bounce_count();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
